// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake on
// both sides.
//
// The WIDTH-bit datapath is cut into STAGES equal slices, LSB slice first.
// Pipeline stage k adds slice k. Inside a slice, 4-bit generate/propagate
// lookahead groups are chained, and the carry ripples from group to group.
// The carry out of each slice is registered and passed to the next stage.
// The operand bits that are not yet summed travel alongside that carry, and so
// do the result bits that are already finished.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of 4*STAGES
//   STAGES  number of pipeline register stages, 1..4
//
// Optional feature
//   CLA_ADDER_PIPE_FLAGS_EN  when defined, the ovf/zero flags are computed and
//                            registered alongside the result. When undefined,
//                            both ports are tied to 0 and no flag registers
//                            exist.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   block can accept operands this cycle
//   a, b       operands
//   cin        carry-in (ignored when sub=1)
//   sub        0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid  result present
//   out_ready  consumer accepts the result
//   sum        result, truncated to WIDTH bits
//   cout       carry out of the MSB (for subtraction, 1 means no borrow)
//   ovf        signed two's-complement overflow
//   zero       sum == 0
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW   = WIDTH / STAGES;  // bits per slice
    localparam int NG   = SW / 4;          // lookahead groups per slice
    localparam int LAST = STAGES - 1;

    // 4-bit carry-lookahead group. Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Subtraction is folded in at the input: invert b and force the carry-in
    // to 1. From here on, every stage is a plain adder.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;

    // Per-stage inputs. Stage 0 takes the ports; stage k>0 takes stage k-1's
    // registers.
    logic [WIDTH-1:0]  st_a   [STAGES];
    logic [WIDTH-1:0]  st_b   [STAGES];
    logic [WIDTH-1:0]  st_s   [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] up_valid;

    // Per-stage combinational results.
    logic [WIDTH-1:0]  s_next [STAGES];
    logic [STAGES-1:0] c_next;

    // Per-stage registered state, gathered into arrays for cross-stage wiring.
    logic [WIDTH-1:0]  a_reg  [STAGES];
    logic [WIDTH-1:0]  b_reg  [STAGES];
    logic [WIDTH-1:0]  s_reg  [STAGES];
    logic [STAGES-1:0] c_reg;
    logic [STAGES-1:0] valid_reg;

    // Handshake. A stage is ready when it is empty or when its contents move
    // on this cycle. The chain runs from out_ready back to in_ready and never
    // involves in_valid.
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] load;

    genvar gi;
    genvar gj;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage

            // ---------------- stage input selection ----------------
            if (gi == 0) begin : g_src_in
                assign st_a[gi]     = a;
                assign st_b[gi]     = b_eff;
                assign st_c[gi]     = cin_eff;
                assign st_s[gi]     = '0;
                assign up_valid[gi] = in_valid;
            end else begin : g_src_prev
                assign st_a[gi]     = a_reg[gi-1];
                assign st_b[gi]     = b_reg[gi-1];
                assign st_c[gi]     = c_reg[gi-1];
                assign st_s[gi]     = s_reg[gi-1];
                assign up_valid[gi] = valid_reg[gi-1];
            end

            // ---------------- flow control ----------------
            if (gi == LAST) begin : g_rdy_out
                assign ready[gi] = !valid_reg[gi] || out_ready;
            end else begin : g_rdy_mid
                assign ready[gi] = !valid_reg[gi] || ready[gi+1];
            end
            assign load[gi] = up_valid[gi] && ready[gi];

            // ---------------- slice adder ----------------
            logic [NG:0]     gc;     // group carries; gc[0] is the slice carry-in
            logic [SW-1:0]   ssum;
            logic [WIDTH-1:0] sn;

            assign gc[0] = st_c[gi];
            for (gj = 0; gj < NG; gj++) begin : g_grp
                logic [4:0] r;
                assign r = cla4(st_a[gi][gi*SW + gj*4 +: 4],
                                st_b[gi][gi*SW + gj*4 +: 4],
                                gc[gj]);
                assign ssum[gj*4 +: 4] = r[3:0];
                assign gc[gj+1]        = r[4];
            end

            // Lower slices carry through unchanged; this stage's slice is
            // overwritten; upper slices are still zero.
            always_comb begin
                sn                = st_s[gi];
                sn[gi*SW +: SW]   = ssum;
            end
            assign s_next[gi] = sn;
            assign c_next[gi] = gc[NG];

            // ---------------- stage registers ----------------
            logic             valid_q;
            logic             c_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    c_q     <= 1'b0;
                    a_q     <= '0;
                    b_q     <= '0;
                    s_q     <= '0;
                end else begin
                    if (ready[gi]) begin
                        valid_q <= up_valid[gi];
                    end
                    if (load[gi]) begin
                        c_q <= c_next[gi];
                        a_q <= st_a[gi];
                        b_q <= st_b[gi];
                        s_q <= s_next[gi];
                    end
                end
            end

            assign valid_reg[gi] = valid_q;
            assign c_reg[gi]     = c_q;
            assign a_reg[gi]     = a_q;
            assign b_reg[gi]     = b_q;
            assign s_reg[gi]     = s_q;
        end
    endgenerate

    // ---------------- outputs ----------------
    assign in_ready  = ready[0];
    assign out_valid = valid_reg[LAST];
    assign sum       = s_reg[LAST];
    assign cout      = c_reg[LAST];

`ifdef CLA_ADDER_PIPE_FLAGS_EN
    // The flags are computed in the last stage from the complete sum. The
    // operand MSBs reach that stage with the rest of the upper operand bits.
    // Subtraction uses the inverted b MSB, which is the effective operand
    // seen by the adder.
    logic ovf_next;
    logic ovf_reg;
    logic zero_reg;

    assign ovf_next = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1])
                   && (s_next[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else if (load[LAST]) begin
            ovf_reg  <= ovf_next;
            zero_reg <= (s_next[LAST] == '0);
        end
    end

    assign ovf  = ovf_reg;
    assign zero = zero_reg;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule
